// File: rtl/mapu_cmd_arb.sv
// mapu_cmd_arb
//   Two-requester command arbiter in front of a single Matrix APU engine.
//   A round-robin winner is accepted in IDLE. Its operands are registered and
//   issued to the engine with a one-cycle start pulse. The arbiter then waits
//   for the engine to finish, or for the timeout to expire, and returns the
//   result to the owning requester through a valid/ready response handshake.
//
//   state | meaning
//   IDLE  | arbitrate, accept one command
//   ISSUE | eng_start pulse, clear timeout counter
//   WAIT  | wait for eng_done or timeout
//   RESP  | present response to owner until rsp_ready
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   req_valid/req_ready[1:0] per-requester command handshake
//   req_op[3:0]              2-bit opcode per requester
//   req_a/req_b              DATA_WIDTH operand slice per requester
//   rsp_valid/rsp_ready[1:0] per-requester response handshake
//   rsp_data, rsp_err        shared response payload
//   eng_start/op/a/b         engine command
//   eng_done/result/err      engine completion
//   busy                     high whenever not IDLE

module mapu_cmd_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [3:0]              req_op,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    eng_start,
  output logic [1:0]              eng_op,
  output logic [DATA_WIDTH-1:0]   eng_a,
  output logic [DATA_WIDTH-1:0]   eng_b,
  input  logic                    eng_done,
  input  logic [DATA_WIDTH-1:0]   eng_result,
  input  logic                    eng_err,
  output logic                    busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  grant_idx;
  logic                  any_valid;

  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    any_valid = |req_valid;
    if (req_valid == 2'b11) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = req_valid[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    eng_start    = 1'b0;
    busy         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // Gated with reset so req_ready reads 0 while reset is held.
        if (any_valid && !reset) begin
          req_ready = grant_idx ? 2'b10 : 2'b01;
          owner_d   = grant_idx;
          op_d      = grant_idx ? req_op[3:2] : req_op[1:0];
          a_d       = grant_idx ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
          b_d       = grant_idx ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (eng_done) begin
          data_d  = eng_result;
          err_d   = eng_err;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign eng_op   = op_q;
  assign eng_a    = a_q;
  assign eng_b    = b_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_mapu_cmd_arb.sv
module tb_mapu_cmd_arb;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [3:0]    req_op;
  logic [2*DW-1:0] req_a, req_b;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          eng_start;
  logic [1:0]    eng_op;
  logic [DW-1:0] eng_a, eng_b;
  logic          eng_done;
  logic [DW-1:0] eng_result;
  logic          eng_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: who won the last completed response.
  int model_last = 1;
  logic [1:0]    op_in [2];
  logic [DW-1:0] a_in  [2];
  logic [DW-1:0] b_in  [2];

  mapu_cmd_arb #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .eng_err(eng_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < 2; i++) begin
      op_in[i] = 2'($urandom_range(0, 3));
      a_in[i]  = $urandom;
      b_in[i]  = $urandom;
    end
  endtask

  // One full command. lat = WAIT cycle (1-based) at which eng_done is pulsed;
  // lat > TO means the engine never answers. bp = cycles of response backpressure.
  task automatic run_txn(input logic [1:0] vmask, input int lat, input int bp,
                         input logic [DW-1:0] res, input logic rerr, output int gnt);
    int            g;
    logic [1:0]    eop;
    logic [DW-1:0] ea, eb, ed;
    logic          ee;
    logic          done;
    logic [1:0]    own;
    req_op    = {op_in[1], op_in[0]};
    req_a     = {a_in[1], a_in[0]};
    req_b     = {b_in[1], b_in[0]};
    req_valid = vmask;
    rsp_ready = 2'b00;
    eng_done  = 1'b0;
    #1;
    g   = (vmask == 2'b11) ? (1 - model_last) : int'(vmask[1]);
    own = (g == 1) ? 2'b10 : 2'b01;
    eop = op_in[g]; ea = a_in[g]; eb = b_in[g];
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b exp 0", busy); end
    checks++; if (req_ready !== own) begin errors++; $display("FAIL grant: got %b exp %b", req_ready, own); end
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ready_issue: got %b exp 00", req_ready); end
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %0b exp 1", eng_start); end
    checks++; if ({eng_op, eng_a, eng_b} !== {eop, ea, eb})
      begin errors++; $display("FAIL eng_cmd: got %h/%h/%h exp %h/%h/%h", eng_op, eng_a, eng_b, eop, ea, eb); end
    step();
    done = 1'b0;
    for (int w = 0; w < TO && !done; w++) begin
      checks++; if (eng_start !== 1'b0 || busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00)
        begin errors++; $display("FAIL wait_ctl: got start=%0b busy=%0b rv=%b rr=%b exp 0/1/00/00", eng_start, busy, rsp_valid, req_ready); end
      checks++; if ({eng_op, eng_a, eng_b} !== {eop, ea, eb})
        begin errors++; $display("FAIL eng_stable: got %h/%h/%h exp %h/%h/%h", eng_op, eng_a, eng_b, eop, ea, eb); end
      eng_result = $urandom;
      eng_err    = 1'($urandom_range(0, 1));
      if (w == lat - 1) begin
        eng_done = 1'b1; eng_result = res; eng_err = rerr; done = 1'b1;
      end
      step();
      eng_done = 1'b0;
      eng_result = $urandom;
    end
    ed = done ? res : '0;
    ee = done ? rerr : 1'b1;
    for (int k = 0; k < bp; k++) begin
      rsp_ready  = (g == 1) ? 2'b01 : 2'b10;
      eng_done   = 1'($urandom_range(0, 1));
      eng_result = $urandom;
      eng_err    = 1'($urandom_range(0, 1));
      #1;
      checks++; if (rsp_valid !== own || rsp_data !== ed || rsp_err !== ee)
        begin errors++; $display("FAIL rsp_hold: got rv=%b d=%h e=%0b exp rv=%b d=%h e=%0b", rsp_valid, rsp_data, rsp_err, own, ed, ee); end
      checks++; if (req_ready !== 2'b00 || busy !== 1'b1)
        begin errors++; $display("FAIL rsp_block: got rr=%b busy=%0b exp 00/1", req_ready, busy); end
      step();
    end
    eng_done  = 1'b0;
    rsp_ready = own;
    #1;
    checks++; if (rsp_valid !== own || rsp_data !== ed || rsp_err !== ee)
      begin errors++; $display("FAIL rsp: got rv=%b d=%h e=%0b exp rv=%b d=%h e=%0b", rsp_valid, rsp_data, rsp_err, own, ed, ee); end
    step();
    rsp_ready  = 2'b00;
    model_last = g;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00)
      begin errors++; $display("FAIL back_idle: got busy=%0b rv=%b exp 0/00", busy, rsp_valid); end
    gnt = g;
  endtask

  task automatic do_reset();
    req_valid = 2'b00; rsp_ready = 2'b00; eng_done = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_last = 1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; eng_done = 1'b1;
    eng_result = 32'hDEAD_BEEF; eng_err = 1'b1;
    step(); step();
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || eng_start !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_ctl: got rr=%b rv=%b st=%0b busy=%0b exp all 0", req_ready, rsp_valid, eng_start, busy); end
    checks++; if (rsp_data !== '0 || rsp_err !== 1'b0 || eng_op !== 2'b00 || eng_a !== '0 || eng_b !== '0)
      begin errors++; $display("FAIL reset_data: got d=%h e=%0b op=%h a=%h b=%h exp 0", rsp_data, rsp_err, eng_op, eng_a, eng_b); end
    eng_done = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    int g;
    op_in[0] = 2'd2; a_in[0] = 32'd5; b_in[0] = 32'd7;
    op_in[1] = 2'd0; a_in[1] = '0;   b_in[1] = '0;
    run_txn(2'b01, 3, 0, a_in[0] * b_in[0], 1'b0, g);
    checks++; if (g != 0) begin errors++; $display("FAIL single_owner: got %0d exp 0", g); end
    req_valid = 2'b00;
  endtask

  task automatic test_contention();
    int g;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rand_operands();
      run_txn(2'b11, $urandom_range(1, TO), 0, $urandom, 1'($urandom_range(0, 1)), g);
      checks++; if (g != (i % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d exp %0d", i, g, i % 2); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    int g;
    rand_operands();
    run_txn(2'b10, TO + 5, 0, 32'h1234, 1'b0, g);
    req_valid = 2'b00;
  endtask

  task automatic test_same_cycle();
    int g;
    rand_operands();
    run_txn(2'b01, TO, 0, 32'd9, 1'b0, g);
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    int g;
    rand_operands();
    run_txn(2'b11, 2, 10, $urandom, 1'b0, g);
    req_valid = 2'b00;
  endtask

  task automatic test_reset_wait();
    int g;
    rand_operands();
    req_op = {op_in[1], op_in[0]}; req_a = {a_in[1], a_in[0]}; req_b = {b_in[1], b_in[0]};
    req_valid = 2'b01;
    step();               // accept
    req_valid = 2'b00;
    step();               // issue
    step();               // wait
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_pre: got %0b exp 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || eng_start !== 1'b0 || eng_a !== '0 || eng_op !== 2'b00)
      begin errors++; $display("FAIL rw_async: got busy=%0b rv=%b st=%0b a=%h op=%h exp 0", busy, rsp_valid, eng_start, eng_a, eng_op); end
    step();
    reset = 1'b0;
    model_last = 1;
    step(); step();
    eng_done = 1'b1; eng_result = 32'hCAFE; eng_err = 1'b0;
    step();
    eng_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
        begin errors++; $display("FAIL rw_ignore: got rv=%b busy=%0b exp 00/0", rsp_valid, busy); end
      step();
    end
    rand_operands();
    run_txn(2'b11, 1, 0, $urandom, 1'b0, g);
    checks++; if (g != 0) begin errors++; $display("FAIL rw_next: got %0d exp 0", g); end
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    int g;
    logic [1:0] vm;
    for (int i = 0; i < 40; i++) begin
      rand_operands();
      vm = 2'($urandom_range(1, 3));
      run_txn(vm, $urandom_range(1, TO + 1), $urandom_range(0, 3), $urandom,
              1'($urandom_range(0, 1)), g);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 2'b00;
        step();
      end
    end
    req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 2'b00; eng_done = 1'b0; eng_result = '0; eng_err = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_same_cycle();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mapu_cmd_arb.md
MAPU_CMD_ARB -- requirements
Module: mapu_cmd_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand and result width of the Matrix APU engine.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, the maximum WAIT-state cycles before the engine is declared hung; legal range 2..65536.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, all logic on rising edge.
REQ-004 SHALL have reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have req_valid  in  2  per-requester command valid; bit i belongs to requester i.
REQ-006 SHALL have req_ready  out  2  per-requester command accept.
REQ-007 SHALL have req_op  in  4  opcodes; bits [2i+1:2i] belong to requester i.
REQ-008 SHALL have req_a and req_b  in  2*DATA_WIDTH each  operands; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have rsp_valid  out  2  and rsp_ready  in  2, the per-requester response handshake.
REQ-010 SHALL have rsp_data  out  DATA_WIDTH  result, and rsp_err  out  1  error flag; both shared by the two requesters.
REQ-011 SHALL have eng_start  out  1  (one-cycle start pulse), eng_op  out  2, and eng_a and eng_b  out  DATA_WIDTH each.
REQ-012 SHALL have eng_done  in  1, eng_result  in  DATA_WIDTH, eng_err  in  1, and busy  out  1.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE, SHALL select a winner g among the asserted req_valid bits and drive req_ready[g]=1 combinationally; all other req_ready bits SHALL be 0.
REQ-015 Outside IDLE, SHALL hold req_ready=2'b00.
REQ-016 Arbitration SHALL be round-robin: with both requesters valid, the winner is the requester that is not last_grant; with one valid, that requester wins.
REQ-017 On an IDLE handshake, SHALL register op, a and b from slice g and latch g as the current owner; next state ISSUE.
REQ-018 In ISSUE, SHALL drive eng_start=1 for exactly one cycle, with eng_op/eng_a/eng_b carrying the registered values; next state WAIT, with the timeout counter cleared.
REQ-019 eng_op/eng_a/eng_b SHALL remain stable from ISSUE until leaving WAIT.
REQ-020 In WAIT, on eng_done=1, SHALL capture eng_result into rsp_data and eng_err into rsp_err; next state RESP.
REQ-021 In WAIT, the counter SHALL increment each cycle without eng_done.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 without eng_done, SHALL set rsp_data=0 and rsp_err=1; next state RESP.
REQ-023 If eng_done and timeout expiry occur in the same cycle, eng_done SHALL win.
REQ-024 eng_done outside WAIT SHALL be ignored with no state change.
REQ-025 In RESP, SHALL drive rsp_valid[owner]=1 only, with rsp_data and rsp_err held stable until rsp_ready[owner]=1.
REQ-026 On the RESP handshake, SHALL set last_grant=owner; next state IDLE.
REQ-027 rsp_ready on the non-owner bit SHALL be ignored.
REQ-028 Minimum latency SHALL be: accept at cycle 0, eng_start at cycle 1, and rsp_valid the cycle after eng_done.
REQ-029 An idle cycle SHALL separate back-to-back commands: a new accept occurs no earlier than the cycle after the RESP handshake.
REQ-030 busy SHALL equal 1 whenever state != IDLE.

Reset
REQ-031 On reset assertion, SHALL asynchronously enter IDLE.
REQ-032 On reset, SHALL clear req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_op, eng_a, eng_b, the counter and busy to 0.
REQ-033 On reset, SHALL set last_grant=1, so requester 0 wins the first contention.
REQ-034 Reset mid-operation SHALL drop the in-flight command without issuing a response; an eng_done arriving after reset SHALL be ignored per REQ-024.

Verification
REQ-035 Single command: req0 op=2, a=5, b=7; engine returns done at WAIT cycle 3 with result=35, err=0 -> eng_start pulses at cycle 1; rsp_valid=2'b01 with rsp_data=35, rsp_err=0.
REQ-036 Contention: both requesters valid after reset -> req0 served first, then req1.
REQ-037 Repeated contention: repeat REQ-036 twice more -> grant order 0,1,0,1,0,1.
REQ-038 Timeout: TIMEOUT_CYCLES=4, engine never asserts done -> RESP entered after 4 WAIT cycles with rsp_data=0, rsp_err=1.
REQ-039 Same-cycle event: eng_done coincides with the timeout cycle, eng_result=9 -> rsp_data=9, rsp_err=0.
REQ-040 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable throughout, and no new req_ready is asserted.
REQ-041 Reset in WAIT: assert reset in WAIT, then pulse eng_done 2 cycles after release -> no rsp_valid, busy=0, and the next command is accepted normally.
